// File: rtl/lut_ln.sv
// Iterative -ln(y) unit: resolves one 4.16 result bit per cycle by greedy
// multiplication with the e^-(2^(k-16)) constant table, valid/ready on both sides.
module lut_ln #(
  parameter int unsigned data_size = 32,
  parameter int unsigned frac_bits = 16,
  parameter int unsigned lut_depth = 20
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic [data_size-1:0] lut_ln_data_i,
  input  logic                 lut_ln_data_valid_i,
  output logic                 lut_ln_ready_o,
  output logic [data_size-1:0] lut_ln_data_o,
  output logic                 lut_ln_data_valid_o,
  input  logic                 lut_ln_ready_i
);

  localparam int unsigned KW = $clog2(lut_depth);
  localparam int unsigned PW = 2 * data_size;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  state_e               state_q, state_d;
  logic [data_size-1:0] p_q, p_d;
  logic [data_size-1:0] y_q, y_d;
  logic [KW-1:0]        k_q, k_d;
  logic [lut_depth-1:0] acc_q, acc_d;
  logic [data_size-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ready_q, ready_d;
  logic [PW-1:0]        prod;
  logic [data_size-1:0] cand;

  // e^-(2^(k-16)) as a 16-bit fraction
  function automatic logic [frac_bits-1:0] lut_val(input logic [KW-1:0] k);
    case (k)
      KW'(19): lut_val = 16'h0015;
      KW'(18): lut_val = 16'h04B0;
      KW'(17): lut_val = 16'h22A5;
      KW'(16): lut_val = 16'h5E2D;
      KW'(15): lut_val = 16'h9B45;
      KW'(14): lut_val = 16'hC75F;
      KW'(13): lut_val = 16'hE1EB;
      KW'(12): lut_val = 16'hF07D;
      KW'(11): lut_val = 16'hF81F;
      KW'(10): lut_val = 16'hFC07;
      KW'(9):  lut_val = 16'hFE01;
      KW'(8):  lut_val = 16'hFF00;
      KW'(7):  lut_val = 16'hFF80;
      KW'(6):  lut_val = 16'hFFC0;
      KW'(5):  lut_val = 16'hFFE0;
      KW'(4):  lut_val = 16'hFFF0;
      KW'(3):  lut_val = 16'hFFF8;
      KW'(2):  lut_val = 16'hFFFC;
      KW'(1):  lut_val = 16'hFFFE;
      default: lut_val = 16'hFFFF;
    endcase
  endfunction

  // Candidate product uses the upper half of a full-width multiply, as in the exp stage
  always_comb begin
    prod = PW'(p_q) * PW'({lut_val(k_q), frac_bits'(0)});
    cand = data_size'(prod >> data_size);
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    y_d     = y_q;
    k_d     = k_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (lut_ln_data_valid_i) begin
          y_d = lut_ln_data_i;
          if (lut_ln_data_i == '0) begin
            acc_d   = '1;
            state_d = DONE;
          end else begin
            p_d     = '1;
            acc_d   = '0;
            k_d     = KW'(lut_depth - 1);
            state_d = ITER;
          end
        end
      end
      ITER: begin
        if (cand >= y_q) begin
          p_d        = cand;
          acc_d[k_q] = 1'b1;
        end else begin
          acc_d[k_q] = 1'b0;
        end
        if (k_q == '0) state_d = DONE;
        else           k_d     = k_q - 1'b1;
      end
      DONE: begin
        if (valid_q && lut_ln_ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
          data_d  = data_size'(acc_q);
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      p_q     <= '0;
      y_q     <= '0;
      k_q     <= KW'(lut_depth - 1);
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      y_q     <= y_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign lut_ln_ready_o      = ready_q;
  assign lut_ln_data_o       = data_q;
  assign lut_ln_data_valid_o = valid_q;

endmodule

// File: tb/tb_lut_ln.sv
// Scoreboard bench for lut_ln: directed corner cases, backpressure, mid-run reset,
// random inputs and exp->ln round trips against a reference model.
module tb_lut_ln;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;

  lut_ln dut (
    .clock_i            (clk),
    .reset_n_i          (rst_n),
    .lut_ln_data_i      (data_i),
    .lut_ln_data_valid_i(valid_i),
    .lut_ln_ready_o     (ready_o),
    .lut_ln_data_o      (data_o),
    .lut_ln_data_valid_o(valid_o),
    .lut_ln_ready_i     (ready_i)
  );

  typedef struct {
    logic [31:0] data;
    int          acc_cyc;
    int          lat;
    bit          use_tol;
    longint      refx;
    longint      tol;
  } exp_t;

  exp_t     q[$];
  int       n_cmp  = 0;
  int       n_fail = 0;
  int       cyc    = 0;
  int       rdy_mode = 1;
  bit       prev_v = 0;
  bit       hs_pend = 0;
  longint unsigned lut_t [20];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    lut_t = '{64'hFFFF, 64'hFFFE, 64'hFFFC, 64'hFFF8, 64'hFFF0, 64'hFFE0, 64'hFFC0,
              64'hFF80, 64'hFF00, 64'hFE01, 64'hFC07, 64'hF81F, 64'hF07D, 64'hE1EB,
              64'hC75F, 64'h9B45, 64'h5E2D, 64'h22A5, 64'h04B0, 64'h0015};
  end

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic chk_tol(input string nm, input longint act, input longint refx, input longint tol);
    longint d;
    d = (act > refx) ? act - refx : refx - act;
    n_cmp++;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h +/- %0d", nm, act, refx, tol);
    end
  endtask

  // -ln(y): greedily keep each power-of-two step of x whose exp factor keeps the product >= y
  function automatic logic [31:0] ref_ln(input logic [31:0] y);
    longint unsigned p, c;
    logic [31:0] r;
    if (y == 0) return 32'h000FFFFF;
    p = 64'hFFFFFFFF;
    r = '0;
    for (int k = 19; k >= 0; k--) begin
      c = (p * lut_t[k]) >> 16;
      if (c >= {32'h0, y}) begin
        p = c;
        r[k] = 1'b1;
      end
    end
    return r;
  endfunction

  // exp stage: y = product of e^-(2^(k-16)) over the set bits of x
  function automatic logic [31:0] exp_model(input logic [31:0] x);
    longint unsigned p;
    p = 64'hFFFFFFFF;
    for (int k = 19; k >= 0; k--)
      if (x[k]) p = (p * lut_t[k]) >> 16;
    return p[31:0];
  endfunction

  task automatic send(input logic [31:0] y, input bit hold, input bit use_tol,
                      input longint refx, input longint tol);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    data_i  = y;
    valid_i = 1'b1;
    while (!ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("accept_timeout", 0, 1);
      valid_i = 1'b0;
      return;
    end
    e.data    = ref_ln(y);
    e.acc_cyc = cyc + 1;
    e.lat     = (y == 0) ? 1 : 21;
    e.use_tol = use_tol;
    e.refx    = refx;
    e.tol     = tol;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) begin
      valid_i = 1'b0;
      data_i  = $urandom;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || valid_o) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      chk("drain_timeout", longint'(q.size()), 0);
      q.delete();
    end
  endtask

  // Downstream ready driver, updated just after each rising edge
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ready_i = 1'b0;
        1:       ready_i = 1'b1;
        default: ready_i = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Monitor: compares every presented result against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v  = 0;
        hs_pend = 0;
        continue;
      end
      if (hs_pend) begin
        chk("ready_after_handshake", longint'(ready_o), 1);
        hs_pend = 0;
      end
      if (valid_o) begin
        chk("ready_low_while_valid", longint'(ready_o), 0);
        if (q.size() == 0) begin
          chk("unexpected_output", longint'(data_o), -1);
        end else begin
          e = q[0];
          chk("data", longint'(data_o), longint'(e.data));
          if (!prev_v) begin
            chk("latency", longint'(cyc - e.acc_cyc), longint'(e.lat));
            if (e.use_tol) chk_tol("tolerance", longint'(data_o), e.refx, e.tol);
          end
          if (ready_i) begin
            void'(q.pop_front());
            hs_pend = 1;
          end
        end
      end
      prev_v = valid_o;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] y, x;
    int          n;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    #12;
    chk("rst_ready", longint'(ready_o), 1);
    chk("rst_valid", longint'(valid_o), 0);
    chk("rst_data",  longint'(data_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    send(32'hFFFFFFFF, 0, 1, 0, 0);
    drain();
    send(32'h5E2CFFFF, 0, 1, 64'h10000, 0);
    send(32'h7FFFFFFF, 0, 1, 64'hB172, 4);
    send(32'h00000000, 0, 1, 64'hFFFFF, 0);
    send(32'h00000001, 0, 1, 64'hFFFFF, 0);
    drain();

    // result must hold while downstream stalls
    rdy_mode = 0;
    send(32'h40000000, 0, 0, 0, 0);
    n = 0;
    while (!valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", longint'(valid_o), 1);
    repeat (10) @(negedge clk);
    rdy_mode = 1;
    drain();

    // second request held valid while busy is taken only after return to idle
    send(32'h12345678, 1, 0, 0, 0);
    send(32'h00ABCDEF, 0, 0, 0, 0);
    drain();

    // asynchronous reset in the middle of an iteration
    send(32'h30000000, 0, 0, 0, 0);
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", longint'(ready_o), 1);
    chk("midrst_valid", longint'(valid_o), 0);
    chk("midrst_data",  longint'(data_o), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(32'hFFFFFFFF, 0, 0, 0, 0);
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       y = $urandom;
        1:       y = $urandom >> $urandom_range(0, 31);
        2:       y = $urandom_range(0, 3);
        default: y = 32'hFFFFFFFF - $urandom_range(0, 1000);
      endcase
      send(y, 0, 0, 0, 0);
    end
    drain();

    for (int i = 0; i < 15; i++) begin
      x = $urandom_range(0, 32'h00060000);
      send(exp_model(x), 0, 1, longint'(x), 8);
    end
    drain();
    rdy_mode = 1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
